// File: rtl/arbiter_pkg.sv
// Shared definitions for the round-robin crossbar arbiters.
// Port indices, FSM state type and one-hot helpers.
package arbiter_pkg;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  function automatic logic [31:0] onehot2bin(
    input logic [31:0] oh
  );
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++)
      if (oh[i]) b = b | 32'(i);
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter_hold_if.sv
// Request/grant bundle between requesters and one arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter_hold_if #(
  parameter int NUM_PORTS = 5,
  parameter int ID_W      = 3
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 preempt;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output preempt
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority search: first set bit of mask
// starting at last+1 and wrapping back to last.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int ID_W      = 3
) (
  input  logic [NUM_PORTS-1:0] i_mask,
  input  logic [ID_W-1:0]      i_last,
  output logic [NUM_PORTS-1:0] o_winner,
  output logic [ID_W-1:0]      o_win_id
);

  logic [NUM_PORTS-1:0] w_win;
  logic                 w_found;
  int                   w_j;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_j = (int'(i_last) + k) % NUM_PORTS;
      if (!w_found && i_mask[w_j]) begin
        w_found    = 1'b1;
        w_win[w_j] = 1'b1;
      end
    end
  end

  assign o_winner = w_win;
  assign o_win_id = ID_W'(onehot2bin(32'(w_win)));

endmodule

// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter with wormhole grant lock and an
// optional hold limit that forces rotation under contention.
module rr_arbiter_hold
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int MAX_HOLD  = 16,
  parameter int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic clk,
  input  logic reset,
  rr_arbiter_hold_if.slave bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_PORTS - 1);

  arb_state_t           r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
  logic [ID_W-1:0]      r_id, w_id_nxt;
  logic [ID_W-1:0]      r_last, w_last_nxt;
  logic [HW-1:0]        r_hold, w_hold_nxt;
  logic                 r_pre, w_pre_nxt;

  logic [NUM_PORTS-1:0] w_mask, w_win;
  logic [ID_W-1:0]      w_win_id;
  logic                 w_own_req, w_others;
  logic                 w_limit, w_keep;

  // The owner bit is masked so a forced rotation never re-picks it;
  // on a voluntary release that bit is already low.
  assign w_mask    = bus.req & ~r_grant;
  assign w_own_req = |(bus.req & r_grant);
  assign w_others  = |w_mask;
  assign w_limit   = (MAX_HOLD != 0) && (r_hold >= HOLD_MAX);
  assign w_keep    = w_own_req && !(w_limit && w_others);

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_pick (
    .i_mask   (w_mask),
    .i_last   (r_last),
    .o_winner (w_win),
    .o_win_id (w_win_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_id    <= '0;
      r_last  <= LAST_RST;
      r_hold  <= '0;
      r_pre   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_pre   <= w_pre_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:
        if (|bus.req) w_state_nxt = OWNED;
      OWNED:
        if (!w_keep && !w_others) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_grant_nxt = r_grant;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_pre_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_grant_nxt = w_win;
          w_id_nxt    = w_win_id;
          w_last_nxt  = w_win_id;
          w_hold_nxt  = HW'(1);
        end
      end
      OWNED: begin
        if (w_keep) begin
          if (MAX_HOLD != 0 && r_hold < HOLD_MAX)
            w_hold_nxt = r_hold + HW'(1);
        end else if (w_others) begin
          w_grant_nxt = w_win;
          w_id_nxt    = w_win_id;
          w_last_nxt  = w_win_id;
          w_hold_nxt  = HW'(1);
          w_pre_nxt   = w_own_req;
        end else begin
          w_grant_nxt = '0;
          w_id_nxt    = '0;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_id_nxt    = '0;
      end
    endcase
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = |r_grant;
  assign bus.grant_id    = r_id;
  assign bus.preempt     = r_pre;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold (5 ports, hold limit 4).
// Expected grants are hand-derived per step.
module tb_rr_arbiter_hold;

  logic clk;
  logic reset;
  int   n_tot;
  int   n_bad;

  rr_arbiter_hold_if #(.NUM_PORTS(5), .ID_W(3)) bus ();

  rr_arbiter_hold #(
    .NUM_PORTS (5),
    .MAX_HOLD  (4),
    .ID_W      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(
    input string      tag,
    input logic [4:0] g,
    input logic [2:0] id,
    input logic       pre
  );
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(|g));
    chk({tag, ".id"}, 32'(bus.grant_id), 32'(id));
    chk({tag, ".pre"}, 32'(bus.preempt), 32'(pre));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tot   = 0;
    n_bad   = 0;
    reset   = 1'b1;
    bus.req = 5'b00000;
    #3;
    expect_out("rst", 5'b00000, 3'd0, 1'b0);
    step();
    reset = 1'b0;
    step();
    expect_out("idle0", 5'b00000, 3'd0, 1'b0);

    bus.req = 5'b11111;
    step();
    expect_out("all_L", 5'b00001, 3'd0, 1'b0);
    bus.req = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("hold_L", 5'b00001, 3'd0, 1'b0);
    end

    bus.req = 5'b00110;
    step();
    expect_out("b2b_N", 5'b00010, 3'd1, 1'b0);
    bus.req = 5'b00100;
    step();
    expect_out("b2b_E", 5'b00100, 3'd2, 1'b0);
    bus.req = 5'b00000;
    step();
    expect_out("rel_E", 5'b00000, 3'd0, 1'b0);

    bus.req = 5'b00101;
    step();
    expect_out("rr_L", 5'b00001, 3'd0, 1'b0);
    bus.req = 5'b11110;
    step();
    expect_out("rr_N", 5'b00010, 3'd1, 1'b0);
    bus.req = 5'b00000;
    step();
    expect_out("rel_N", 5'b00000, 3'd0, 1'b0);

    bus.req = 5'b01000;
    step();
    expect_out("S_c1", 5'b01000, 3'd3, 1'b0);
    step();
    expect_out("S_c2", 5'b01000, 3'd3, 1'b0);
    bus.req = 5'b01010;
    step();
    expect_out("S_c3", 5'b01000, 3'd3, 1'b0);
    step();
    expect_out("S_c4", 5'b01000, 3'd3, 1'b0);
    step();
    expect_out("pre_N", 5'b00010, 3'd1, 1'b1);
    step();
    expect_out("post_N", 5'b00010, 3'd1, 1'b0);
    bus.req = 5'b01000;
    step();
    expect_out("back_S", 5'b01000, 3'd3, 1'b0);
    bus.req = 5'b00000;
    step();
    expect_out("rel_S", 5'b00000, 3'd0, 1'b0);

    bus.req = 5'b10000;
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("solo_W", 5'b10000, 3'd4, 1'b0);
    end
    bus.req = 5'b00000;
    step();
    expect_out("rel_W", 5'b00000, 3'd0, 1'b0);

    bus.req = 5'b01000;
    step();
    expect_out("pkt_S", 5'b01000, 3'd3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_rst", 5'b00000, 3'd0, 1'b0);
    step();
    reset   = 1'b0;
    bus.req = 5'b11000;
    step();
    expect_out("after_rst", 5'b01000, 3'd3, 1'b0);
    bus.req = 5'b00000;
    step();
    expect_out("final", 5'b00000, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
